// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline register indices/controls in, stall/flush controls out.
// Performance counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] RsD;
  logic [REG_AW-1:0] RtD;
  logic [REG_AW-1:0] RsE;
  logic [REG_AW-1:0] RtE;
  logic [REG_AW-1:0] WriteRegE;
  logic [REG_AW-1:0] WriteRegM;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemtoRegM;
  logic              BranchD;
  logic              PCSrcD;
  logic              ICACHE_stall;
  logic              DCACHE_stall;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              StallM;
  logic              StallW;
  logic              FlushD;
  logic              FlushE;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  perf_lu_cnt;
  logic [CNT_W-1:0]  perf_frz_cnt;
`endif

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM,
    output RegWriteE, MemtoRegE, MemtoRegM, BranchD, PCSrcD,
    output ICACHE_stall, DCACHE_stall,
`ifdef HAZARD_PERF_CNT_EN
    input  perf_lu_cnt, perf_frz_cnt,
`endif
    input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM,
    input  RegWriteE, MemtoRegE, MemtoRegM, BranchD, PCSrcD,
    input  ICACHE_stall, DCACHE_stall,
`ifdef HAZARD_PERF_CNT_EN
    output perf_lu_cnt, perf_frz_cnt,
`endif
    output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline (load-use, ID-branch, cache freeze).
// Define HAZARD_PERF_CNT_EN to add saturating load-use and freeze cycle counters.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } state_e;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  state_e state_q, state_d;
  logic   flush_pend_q, flush_pend_d;
  logic   match_e_s, match_m_s;
  logic   lu_s, br_s, hzd_s, frz_s, take_s;
  logic   stall_fd_s, stall_emw_s, flush_d_s, flush_e_s;

  function automatic logic reg_match(input logic [REG_AW-1:0] wr,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt);
    return (wr != REG_ZERO) && ((wr == rs) || (wr == rt));
  endfunction

  assign match_e_s = reg_match(hz.WriteRegE, hz.RsD, hz.RtD);
  assign match_m_s = reg_match(hz.WriteRegM, hz.RsD, hz.RtD);
  assign lu_s      = hz.MemtoRegE & match_e_s;
  // An ALU result in EX/MEM is bypassed to the ID comparator, so only loads stall a branch.
  assign br_s      = hz.BranchD & ((hz.RegWriteE & hz.MemtoRegE & match_e_s) |
                                   (hz.MemtoRegM & match_m_s));
  assign hzd_s     = lu_s | br_s;
  assign frz_s     = hz.ICACHE_stall | hz.DCACHE_stall;
  assign take_s    = hz.PCSrcD & ~hzd_s;

  // Next-state and stall/flush decode; a freeze overrides every other request.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    stall_fd_s   = 1'b0;
    stall_emw_s  = 1'b0;
    flush_d_s    = 1'b0;
    flush_e_s    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (frz_s) begin
          state_d      = ST_FREEZE;
          flush_pend_d = take_s;
          stall_fd_s   = 1'b1;
          stall_emw_s  = 1'b1;
        end else begin
          stall_fd_s = hzd_s;
          flush_e_s  = hzd_s;
          flush_d_s  = take_s;
        end
      end
      ST_FREEZE: begin
        if (frz_s) begin
          flush_pend_d = flush_pend_q | take_s;
          stall_fd_s   = 1'b1;
          stall_emw_s  = 1'b1;
        end else begin
          state_d      = ST_RUN;
          flush_pend_d = 1'b0;
          stall_fd_s   = hzd_s;
          flush_e_s    = hzd_s;
          flush_d_s    = take_s | flush_pend_q;
        end
      end
      default: begin
        state_d      = ST_RUN;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  // FSM state and the taken-branch flush held across a freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // While reset is asserted the pipeline is held bubbled with no stage frozen.
  assign hz.StallF = rst_n & stall_fd_s;
  assign hz.StallD = rst_n & stall_fd_s;
  assign hz.StallE = rst_n & stall_emw_s;
  assign hz.StallM = rst_n & stall_emw_s;
  assign hz.StallW = rst_n & stall_emw_s;
  assign hz.FlushD = ~rst_n | flush_d_s;
  assign hz.FlushE = ~rst_n | flush_e_s;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] frz_cnt_q, frz_cnt_d;

  // Saturating increments for the hazard-stall and freeze cycle counters.
  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    frz_cnt_d = frz_cnt_q;
    if (~frz_s & hzd_s & (lu_cnt_q != CNT_MAX)) begin
      lu_cnt_d = lu_cnt_q + CNT_ONE;
    end else begin
      lu_cnt_d = lu_cnt_q;
    end
    if (frz_s & (frz_cnt_q != CNT_MAX)) begin
      frz_cnt_d = frz_cnt_q + CNT_ONE;
    end else begin
      frz_cnt_d = frz_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q  <= '0;
      frz_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      frz_cnt_q <= frz_cnt_d;
    end
  end

  assign hz.perf_lu_cnt  = lu_cnt_q;
  assign hz.perf_frz_cnt = frz_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_s;
  assign unused_cnt_s = '0;
`endif

  // EX source registers are carried on the bundle for symmetry only.
  logic unused_s;
  assign unused_s = ^{hz.RsE, hz.RtE};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; outputs checked as {StallF,D,E,M,W,FlushD,FlushE}.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_run  = 0;
  int   n_fail = 0;

  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_RST  = 7'b0000011;
  localparam logic [6:0] O_LU   = 7'b1100001;
  localparam logic [6:0] O_FRZ  = 7'b1111100;
  localparam logic [6:0] O_FD   = 7'b0000010;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz_if ();

  hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if)
  );

  always #5 clk = ~clk;

  task automatic clr();
    hz_if.RsD = 5'd0; hz_if.RtD = 5'd0; hz_if.RsE = 5'd0; hz_if.RtE = 5'd0;
    hz_if.WriteRegE = 5'd0; hz_if.WriteRegM = 5'd0;
    hz_if.RegWriteE = 1'b0; hz_if.MemtoRegE = 1'b0; hz_if.MemtoRegM = 1'b0;
    hz_if.BranchD = 1'b0; hz_if.PCSrcD = 1'b0;
    hz_if.ICACHE_stall = 1'b0; hz_if.DCACHE_stall = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.StallM, hz_if.StallW,
           hz_if.FlushD, hz_if.FlushE};
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #2 chk("reset", O_RST);
    @(negedge clk); rst_n = 1'b1;
    #2 chk("idle", O_IDLE);

    // lw $2 in EX, add uses $2 in ID
    @(negedge clk); hz_if.MemtoRegE = 1'b1; hz_if.RegWriteE = 1'b1; hz_if.WriteRegE = 5'd2;
    hz_if.RsD = 5'd2; hz_if.RtD = 5'd7;
    #2 chk("lu_stall", O_LU);
    @(negedge clk); clr(); hz_if.RsD = 5'd2; hz_if.RtD = 5'd7;
    #2 chk("lu_after", O_IDLE);

    // beq $3 with ALU producer in EX, then load producer in MEM
    @(negedge clk); clr(); hz_if.BranchD = 1'b1; hz_if.RsD = 5'd3; hz_if.RtD = 5'd1;
    hz_if.WriteRegE = 5'd3; hz_if.RegWriteE = 1'b1;
    #2 chk("br_alu_ex", O_IDLE);
    @(negedge clk); hz_if.WriteRegE = 5'd0; hz_if.RegWriteE = 1'b0;
    hz_if.MemtoRegM = 1'b1; hz_if.WriteRegM = 5'd3;
    #2 chk("br_lw_mem", O_LU);
    @(negedge clk); hz_if.MemtoRegM = 1'b0;
    #2 chk("br_after", O_IDLE);
    @(negedge clk); hz_if.BranchD = 1'b0; hz_if.MemtoRegM = 1'b1;
    #2 chk("mem_lw_nobr", O_IDLE);

    // register 0 never hazards
    @(negedge clk); clr(); hz_if.MemtoRegE = 1'b1; hz_if.RegWriteE = 1'b1;
    #2 chk("r0_lu", O_IDLE);
    @(negedge clk); hz_if.RtD = 5'd5; hz_if.BranchD = 1'b1;
    #2 chk("r0_br", O_IDLE);

    // taken branch without freeze
    @(negedge clk); clr(); hz_if.BranchD = 1'b1; hz_if.PCSrcD = 1'b1; hz_if.RsD = 5'd9;
    #2 chk("taken", O_FD);

    // taken branch under a 4-cycle I-cache freeze
    @(negedge clk); hz_if.ICACHE_stall = 1'b1;
    #2 chk("ifrz_1", O_FRZ);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2 chk("ifrz_n", O_FRZ);
    end
    @(negedge clk); clr();
    #2 chk("ifrz_rel", O_FD);
    @(negedge clk);
    #2 chk("ifrz_post", O_IDLE);

    // D-cache freeze overrides load-use, which appears on release
    @(negedge clk); hz_if.MemtoRegE = 1'b1; hz_if.RegWriteE = 1'b1; hz_if.WriteRegE = 5'd4;
    hz_if.RtD = 5'd4; hz_if.DCACHE_stall = 1'b1;
    #2 chk("dfrz_1", O_FRZ);
    @(negedge clk);
    #2 chk("dfrz_2", O_FRZ);
    @(negedge clk); hz_if.DCACHE_stall = 1'b0;
    #2 chk("dfrz_lu", O_LU);
    @(negedge clk); clr();
    #2 chk("dfrz_post", O_IDLE);

    // back-to-back freezes with one RUN cycle between
    @(negedge clk); hz_if.PCSrcD = 1'b1; hz_if.ICACHE_stall = 1'b1;
    #2 chk("b2b_frz1", O_FRZ);
    @(negedge clk); hz_if.PCSrcD = 1'b0; hz_if.ICACHE_stall = 1'b0;
    #2 chk("b2b_gap", O_FD);
    @(negedge clk); hz_if.ICACHE_stall = 1'b1;
    #2 chk("b2b_frz2", O_FRZ);
    @(negedge clk); hz_if.ICACHE_stall = 1'b0;
    #2 chk("b2b_rel", O_IDLE);

    // reset asserted in the middle of a freeze with a pending flush
    @(negedge clk); hz_if.PCSrcD = 1'b1; hz_if.ICACHE_stall = 1'b1;
    #2 chk("rfrz_1", O_FRZ);
    @(negedge clk);
    #2 chk("rfrz_2", O_FRZ);
    #1 rst_n = 1'b0;
    #1 chk("rfrz_async", O_RST);
    clr();
    @(negedge clk); rst_n = 1'b1;
    #2 chk("rfrz_rel", O_IDLE);
    @(negedge clk);
    #2 chk("rfrz_post", O_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
